// File: rtl/ahf_mbox_pkg.sv
// rtl/ahf_mbox_pkg.sv - shared defaults and sizing helpers for the mailbox switch
package ahf_mbox_pkg;

    localparam int NCORE_DEF = 3;
    localparam int WIDTH_DEF = 14;
    localparam int DEPTH_DEF = 2;

    // Width of one destination field inside the packed Wr_dest bus.
    localparam int DEST_W = 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Pointer width that stays at least one bit for single-entry structures.
    function automatic int ptr_w(input int v);
        return (v > 1) ? clog2(v) : 1;
    endfunction

endpackage

// File: rtl/ahf_mbox_fifo.sv
// rtl/ahf_mbox_fifo.sv - single receive mailbox, first-word-fall-through FIFO
module ahf_mbox_fifo
    import ahf_mbox_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] head
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    last_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            last_ptr <= '0;
            count    <= '0;
            full     <= 1'b0;
            valid    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr] <= push_data;
                wptr      <= inc(wptr);
            end
            if (pop) begin
                rptr     <= inc(rptr);
                last_ptr <= rptr;
            end
            count <= count_nxt;
            full  <= (32'(count_nxt) == DEPTH);
            valid <= (count_nxt != '0);
        end
    end

    // When empty, keep presenting the most recently popped word.
    assign head = valid ? mem[rptr] : mem[last_ptr];

endmodule

// File: rtl/ahf_mbox_arbiter.sv
// rtl/ahf_mbox_arbiter.sv - inter-core mailbox switch with per-mailbox round-robin write arbitration
module ahf_mbox_arbiter
    import ahf_mbox_pkg::*;
#(
    parameter int NCORE = NCORE_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                    Clk_pin0,
    input  logic                    Reset_pin,
    input  logic [NCORE-1:0]        Wr_req,
    input  logic [DEST_W*NCORE-1:0] Wr_dest,
    input  logic [WIDTH*NCORE-1:0]  Wr_data,
    output logic [NCORE-1:0]        Wr_ack,
    input  logic [NCORE-1:0]        Rd_req,
    output logic [WIDTH*NCORE-1:0]  Rd_data,
    output logic [NCORE-1:0]        Rd_valid,
    output logic [NCORE-1:0]        Rd_ack,
    output logic [NCORE-1:0]        Mbox_full,
    output logic [NCORE-1:0]        Err
);

    localparam int RW = ptr_w(NCORE);

    logic [NCORE-1:0]  wr_eff;
    logic [NCORE-1:0]  rd_eff;
    logic [NCORE-1:0]  pop;
    logic [NCORE-1:0]  push;
    logic [NCORE-1:0]  gnt;
    logic [NCORE-1:0]  bad;
    logic [NCORE-1:0]  hit;
    logic [DEST_W-1:0] dst [NCORE];
    logic [RW-1:0]     rr_ptr [NCORE];
    logic [RW-1:0]     win [NCORE];
    logic [RW-1:0]     scan;
    logic [WIDTH-1:0]  push_data [NCORE];

    function automatic logic [RW-1:0] wrap_inc(input logic [RW-1:0] p);
        return (32'(p) == NCORE - 1) ? '0 : p + RW'(1);
    endfunction

    always_comb begin
        // The registered ack doubles as the mask against re-posting a held request.
        wr_eff = Wr_req & ~Wr_ack;
        rd_eff = Rd_req & ~Rd_ack;
        pop    = rd_eff & Rd_valid;
        gnt    = '0;
        bad    = '0;
        push   = '0;
        hit    = '0;
        scan   = '0;
        for (int k = 0; k < NCORE; k++) begin
            dst[k] = Wr_dest[DEST_W*k +: DEST_W];
            bad[k] = wr_eff[k] && ({1'b0, dst[k]} >= (DEST_W+1)'(NCORE));
        end
        for (int d = 0; d < NCORE; d++) begin
            win[d]       = rr_ptr[d];
            push_data[d] = '0;
            scan         = rr_ptr[d];
            for (int i = 0; i < NCORE; i++) begin
                if (!hit[d] && wr_eff[scan] && (dst[scan] == DEST_W'(d))) begin
                    hit[d] = 1'b1;
                    win[d] = scan;
                end
                scan = wrap_inc(scan);
            end
            // A full mailbox still takes a word when it is popped on the same edge.
            push[d] = hit[d] && (!Mbox_full[d] || pop[d]);
            if (push[d]) begin
                gnt[win[d]]  = 1'b1;
                push_data[d] = Wr_data[WIDTH*win[d] +: WIDTH];
            end
        end
    end

    always_ff @(posedge Clk_pin0 or negedge Reset_pin) begin
        if (!Reset_pin) begin
            Wr_ack <= '0;
            Rd_ack <= '0;
            Err    <= '0;
            for (int d = 0; d < NCORE; d++) begin
                rr_ptr[d] <= '0;
            end
        end else begin
            Wr_ack <= gnt | bad;
            Rd_ack <= pop;
            Err    <= Err | bad;
            for (int d = 0; d < NCORE; d++) begin
                if (push[d]) begin
                    rr_ptr[d] <= wrap_inc(win[d]);
                end
            end
        end
    end

    for (genvar d = 0; d < NCORE; d++) begin : g_mbox
        ahf_mbox_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (Clk_pin0),
            .rst_n     (Reset_pin),
            .push      (push[d]),
            .push_data (push_data[d]),
            .pop       (pop[d]),
            .full      (Mbox_full[d]),
            .valid     (Rd_valid[d]),
            .head      (Rd_data[WIDTH*d +: WIDTH])
        );
    end

endmodule

// File: tb/tb_ahf_mbox_arbiter.sv
// tb/tb_ahf_mbox_arbiter.sv - directed self-checking bench for the mailbox switch
module tb_ahf_mbox_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  wr_req;
    logic [5:0]  wr_dest;
    logic [41:0] wr_data;
    logic [2:0]  wr_ack;
    logic [2:0]  rd_req;
    logic [41:0] rd_data;
    logic [2:0]  rd_valid;
    logic [2:0]  rd_ack;
    logic [2:0]  mbox_full;
    logic [2:0]  err;

    int n_tests = 0;
    int n_fail  = 0;

    ahf_mbox_arbiter #(
        .NCORE (3),
        .WIDTH (14),
        .DEPTH (2)
    ) dut (
        .Clk_pin0  (clk),
        .Reset_pin (rst_n),
        .Wr_req    (wr_req),
        .Wr_dest   (wr_dest),
        .Wr_data   (wr_data),
        .Wr_ack    (wr_ack),
        .Rd_req    (rd_req),
        .Rd_data   (rd_data),
        .Rd_valid  (rd_valid),
        .Rd_ack    (rd_ack),
        .Mbox_full (mbox_full),
        .Err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_req  = '0;
        wr_dest = '0;
        wr_data = '0;
        rd_req  = '0;
        step();
        step();
        chk("rst_wr_ack", wr_ack, 3'b000);
        chk("rst_rd_ack", rd_ack, 3'b000);
        chk("rst_rd_valid", rd_valid, 3'b000);
        chk("rst_full", mbox_full, 3'b000);
        chk("rst_err", err, 3'b000);
        chk("rst_rd_data", rd_data, 42'h0);
        rst_n = 1'b1;

        // single post core0 -> mailbox 1, request held one cycle past the ack
        wr_req         = 3'b001;
        wr_dest[1:0]   = 2'd1;
        wr_data[13:0]  = 14'h1234;
        step();
        chk("t1_wr_ack", wr_ack, 3'b001);
        chk("t1_rd_valid", rd_valid, 3'b010);
        chk("t1_rd_data1", rd_data[27:14], 14'h1234);
        step();
        chk("t1_no_dup_ack", wr_ack, 3'b000);
        chk("t1_no_dup_full", mbox_full, 3'b000);
        wr_req = 3'b000;
        rd_req = 3'b010;
        step();
        chk("t1_rd_ack", rd_ack, 3'b010);
        chk("t1_rd_valid_clr", rd_valid, 3'b000);
        chk("t1_rd_data_hold", rd_data[27:14], 14'h1234);
        rd_req = 3'b000;

        // empty read
        rd_req = 3'b010;
        step();
        chk("empty_rd_ack", rd_ack, 3'b000);
        step();
        chk("empty_rd_ack2", rd_ack, 3'b000);
        chk("empty_rd_valid", rd_valid, 3'b000);
        rd_req = 3'b000;

        // contention: cores 0,1,2 -> mailbox 2, mailbox 2 read continuously
        wr_dest  = {2'd2, 2'd2, 2'd2};
        wr_data  = {14'h0A2, 14'h0A1, 14'h0A0};
        wr_req   = 3'b111;
        rd_req   = 3'b100;
        step();
        chk("rr_grant0", wr_ack, 3'b001);
        wr_req = 3'b110;
        step();
        chk("rr_grant1", wr_ack, 3'b010);
        chk("rr_pop_ack", rd_ack, 3'b100);
        chk("rr_head_a1", rd_data[41:28], 14'h0A1);
        wr_req = 3'b100;
        step();
        chk("rr_grant2", wr_ack, 3'b100);
        chk("rr_full2", mbox_full, 3'b100);
        wr_data[27:0] = {14'h0B1, 14'h0B0};
        wr_req = 3'b011;
        step();
        chk("rr_wrap_grant0", wr_ack, 3'b001);
        chk("rr_head_a2", rd_data[41:28], 14'h0A2);
        wr_req = 3'b010;
        step();
        chk("rr_blocked", wr_ack, 3'b000);
        step();
        chk("rr_grant1b", wr_ack, 3'b010);
        chk("rr_head_b0", rd_data[41:28], 14'h0B0);
        wr_req = 3'b000;
        rd_req = 3'b000;

        // back-pressure on mailbox 0
        wr_dest[1:0]  = 2'd0;
        wr_data[13:0] = 14'h0001;
        wr_req        = 3'b001;
        step();
        chk("bp_ack1", wr_ack, 3'b001);
        wr_data[13:0] = 14'h0002;
        step();
        chk("bp_mask1", wr_ack, 3'b000);
        step();
        chk("bp_ack2", wr_ack, 3'b001);
        chk("bp_full", mbox_full[0], 1'b1);
        wr_data[13:0] = 14'h0003;
        step();
        step();
        chk("bp_no_ack3", wr_ack, 3'b000);
        chk("bp_head1", rd_data[13:0], 14'h0001);
        rd_req = 3'b001;
        step();
        chk("bp_ack3", wr_ack, 3'b001);
        chk("bp_rd_ack", rd_ack, 3'b001);
        chk("bp_head2", rd_data[13:0], 14'h0002);
        chk("bp_still_full", mbox_full[0], 1'b1);
        wr_req = 3'b000;
        step();
        step();
        chk("bp_head3", rd_data[13:0], 14'h0003);
        step();
        step();
        chk("bp_drained", rd_valid[0], 1'b0);
        chk("bp_hold3", rd_data[13:0], 14'h0003);
        rd_req = 3'b000;

        // invalid destination from core2
        wr_dest[5:4] = 2'd3;
        wr_req       = 3'b100;
        step();
        chk("inv_err", err, 3'b100);
        chk("inv_ack", wr_ack, 3'b100);
        chk("inv_valid", rd_valid, 3'b100);
        chk("inv_full", mbox_full, 3'b100);
        wr_req = 3'b000;
        step();
        chk("inv_sticky", err, 3'b100);
        chk("inv_ack_clr", wr_ack, 3'b000);

        // fill mailbox 0, reset asynchronously, then repeat the same posts
        wr_dest = {2'd0, 2'd0, 2'd0};
        wr_data = {14'h0C2, 14'h0C1, 14'h0C0};
        wr_req  = 3'b111;
        step();
        chk("pre_rst_grant1", wr_ack, 3'b010);
        wr_req = 3'b101;
        step();
        chk("pre_rst_grant2", wr_ack, 3'b100);
        chk("pre_rst_full", mbox_full[0], 1'b1);
        wr_req = 3'b001;
        step();
        chk("pre_rst_blocked", wr_ack, 3'b000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wr_ack", wr_ack, 3'b000);
        chk("arst_rd_valid", rd_valid, 3'b000);
        chk("arst_full", mbox_full, 3'b000);
        chk("arst_err", err, 3'b000);
        chk("arst_rd_data", rd_data, 42'h0);
        wr_req = 3'b111;
        step();
        chk("arst_no_ack", wr_ack, 3'b000);
        rst_n = 1'b1;
        step();
        chk("post_rst_grant0", wr_ack, 3'b001);
        chk("post_rst_valid", rd_valid, 3'b001);
        chk("post_rst_head", rd_data[13:0], 14'h0C0);
        wr_req = 3'b110;
        step();
        chk("post_rst_grant1", wr_ack, 3'b010);
        wr_req = 3'b000;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ahf_mbox_arbiter.md
Name: ahf_mbox_arbiter

Overview:
- Inter-core mailbox switch that connects the 3-channel Read/Write/Done I/O ports of up to three RISC521 cores.
- Each core owns one receive mailbox, a small FIFO. Any core can post a 14-bit word to any mailbox.
- Concurrent writers to the same mailbox are resolved by a per-mailbox round-robin arbiter.
- Sits at board level between the cores' 0x3F80-0x3FDF memory-mapped I/O windows.

Parameters:
- NCORE, 3: number of cores/mailboxes (2..4).
- WIDTH, 14: data word width.
- DEPTH, 2: mailbox FIFO depth in words (1..4).

Ports:
- Clk_pin0  in  1  system clock, rising edge.
- Reset_pin  in  1  asynchronous active-low reset.
- Wr_req  in  NCORE  bit k: core k requests a post.
- Wr_dest  in  2*NCORE  destination mailbox of core k at [2k+1:2k].
- Wr_data  in  WIDTH*NCORE  word of core k at [WIDTH*k+WIDTH-1:WIDTH*k].
- Wr_ack  out  NCORE  one-cycle pulse: core k's word was accepted.
- Rd_req  in  NCORE  bit d: core d pops its mailbox.
- Rd_data  out  WIDTH*NCORE  head word of mailbox d, first-word-fall-through, same packing as Wr_data.
- Rd_valid  out  NCORE  mailbox d is non-empty.
- Rd_ack  out  NCORE  one-cycle pulse: pop performed.
- Mbox_full  out  NCORE  mailbox d holds DEPTH words.
- Err  out  NCORE  sticky: core k posted to a nonexistent mailbox (dest >= NCORE).

Behaviour:
- Reset is asynchronous and active-low; it overrides everything.
  - Clears all FIFO counts and read/write pointers and all round-robin pointers (each set to 0).
  - Clears the ack masks.
  - Outputs after reset: Wr_ack=0, Rd_ack=0, Rd_valid=0, Mbox_full=0, Err=0, Rd_data=0.
  - Reset mid-transfer discards all stored words; no ack is issued for a request sampled in the reset cycle.
- Effective write request: Wr_req[k] & ~wmask[k].
  - wmask[k] is the registered copy of Wr_ack[k].
  - A writer holding Wr_req one cycle past its ack is therefore never double-posted.
- Per-mailbox write arbitration, evaluated each cycle for every d:
  - Candidates: cores with an effective request and Wr_dest==d.
  - The mailbox accepts a push when count<DEPTH, or when count==DEPTH and a pop of d occurs this same cycle.
  - Winner: first candidate at or after rr_ptr[d], scanning upward modulo NCORE.
  - On push: data is written at the tail; rr_ptr[d] becomes winner+1 mod NCORE; Wr_ack[winner]=1 in the following cycle.
  - Losers and blocked writers get no ack and keep requesting. The pointer moves only on a grant.
  - A core may post to its own mailbox.
- Invalid destination (Wr_dest>=NCORE) with an effective request:
  - Err[k] sets and stays set until reset.
  - Wr_ack[k] pulses next cycle; the word is dropped.
  - This prevents deadlock.
- Read, per mailbox d:
  - Effective request: Rd_req[d] & ~rmask[d], where rmask[d] is the registered copy of Rd_ack[d].
  - Pop happens at the edge when the effective request is high and count>0; Rd_ack[d]=1 in the following cycle.
  - A request on an empty mailbox is ignored, with no ack.
  - Rd_data[d] shows the head word whenever Rd_valid[d]=1 and holds its last value otherwise.
- Simultaneous push and pop on one mailbox:
  - count is unchanged.
  - With count==0, the push cannot bypass to Rd_data in the same cycle (no pop occurs on empty); it appears the next cycle.
- Pointers and wrap-around:
  - Read/write pointers wrap modulo DEPTH.
  - count is a clog2(DEPTH+1)-bit register, never exceeding DEPTH.
- Latency:
  - Post to Rd_valid: 1 cycle after the accepting edge.
  - Request to ack: 1 cycle.
- All outputs are registered except Rd_data, which is a mux from registered FIFO storage.

Decomposition:
- Shared package ahf_mbox_pkg holds:
  - Defaults NCORE_DEF, WIDTH_DEF, DEPTH_DEF.
  - Function clog2.
  - Packed-slice helper constants.
- One natural sub-module, ahf_mbox_fifo: a single-mailbox FIFO with push/pop/count/full/head, instantiated NCORE times by generate.
- Round-robin arbitration stays in the top level.

Test Plan:
- Reset and single post: release reset, core0 posts 14'h1234 to dest 1 → Wr_ack[0] pulses 1 cycle later; Rd_valid[1]=1 with Rd_data[1]=14'h1234. Core1 Rd_req → Rd_ack[1] pulse, Rd_valid[1]=0.
- Contention: cores 0, 1, 2 all post to dest 2 every cycle, holding Wr_req until their own ack, with mailbox 2 popped every cycle → grant order 0, 1, 2, 0…, one ack per cycle, no duplicates.
- Full/back-pressure: DEPTH=2, post 14'h0001 and 14'h0002 to mailbox 0, then a third word 14'h0003 → Mbox_full[0]=1 and no ack for the third. Pop once → third accepted in the pop cycle, drained order is 1, 2, 3.
- Invalid destination: core2 posts to dest 3 → Err[2]=1 (sticky), Wr_ack[2] pulses, no mailbox changes.
- Empty read: Rd_req[1] on an empty mailbox → no Rd_ack, count stays 0.
- Async reset mid-operation: mailbox 0 holding 2 words, assert Reset_pin between clock edges → all outputs 0 immediately. After release, the same post sequence repeats the round-robin from core0.
